// File: rtl/gradient_calc_if.sv
`default_nettype none
// ============================================================================
//  Module   : gradient_calc_if
//  Purpose  : Window-in / gradient-out bundle for the Sobel gradient stage.
//             master = upstream window loader side, slave = gradient stage.
//  Revision : 1.0  initial release
// ============================================================================
interface gradient_calc_if;
    logic [71:0] gradient_data_in;
    logic        gradient_data_in_valid;
    logic [7:0]  pixel_out_x;
    logic [7:0]  pixel_out_y;
    logic        pixel_xy_valid;
    logic [10:0] gradient_magnitude;
    logic [1:0]  gradient_direction;
    logic [7:0]  pixel_out;
    logic        gradient_out_valid;

    modport master (
        output gradient_data_in,
        output gradient_data_in_valid,
        input  pixel_out_x,
        input  pixel_out_y,
        input  pixel_xy_valid,
        input  gradient_magnitude,
        input  gradient_direction,
        input  pixel_out,
        input  gradient_out_valid
    );

    modport slave (
        input  gradient_data_in,
        input  gradient_data_in_valid,
        output pixel_out_x,
        output pixel_out_y,
        output pixel_xy_valid,
        output gradient_magnitude,
        output gradient_direction,
        output pixel_out,
        output gradient_out_valid
    );
endinterface
`default_nettype wire

// File: rtl/gradient_calc.sv
`default_nettype none
// ============================================================================
//  Module   : gradient_calc
//  Purpose  : Two-stage Sobel gradient pipeline. Stage 1 computes Gx/Gy and
//             the clamped X/Y images; stage 2 computes L1 magnitude, the
//             quantised direction and the clamped edge image. 1 window/clk.
//  Revision : 1.0  initial release
// ============================================================================
module gradient_calc (
    input  wire logic       clk,
    input  wire logic       rstN,   // active-high asynchronous reset
    gradient_calc_if.slave  bus
);

    // Direction codes
    localparam logic [1:0] C_DIR_0   = 2'd0;
    localparam logic [1:0] C_DIR_45  = 2'd1;
    localparam logic [1:0] C_DIR_90  = 2'd2;
    localparam logic [1:0] C_DIR_135 = 2'd3;

    // Stage 1 state: Gx/Gy are held as sign + magnitude, which carries the
    // same information as the signed values and is all stage 2 consumes.
    logic        sign_x_q, sign_x_d;
    logic        sign_y_q, sign_y_d;
    logic [9:0]  abs_x_q,  abs_x_d;
    logic [9:0]  abs_y_q,  abs_y_d;
    logic [7:0]  pix_x_q,  pix_x_d;
    logic [7:0]  pix_y_q,  pix_y_d;
    logic        xy_valid_q, xy_valid_d;

    // Stage 2 state
    logic [10:0] mag_q, mag_d;
    logic [1:0]  dir_q, dir_d;
    logic [7:0]  pix_q, pix_d;
    logic        out_valid_q, out_valid_d;

    // Combinational helpers
    logic [7:0]         p [9];
    logic [10:0]        w_x_pos, w_x_neg, w_y_pos, w_y_neg;
    logic signed [10:0] w_gx, w_gy;
    logic [12:0]        w_ax5, w_ax2, w_ay5, w_ay2;

    // Unpack the window and apply both Sobel kernels
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            p[k] = bus.gradient_data_in[8*k +: 8];
        end
        w_x_pos = {3'b0, p[2]} + {2'b0, p[5], 1'b0} + {3'b0, p[8]};
        w_x_neg = {3'b0, p[0]} + {2'b0, p[3], 1'b0} + {3'b0, p[6]};
        w_y_pos = {3'b0, p[6]} + {2'b0, p[7], 1'b0} + {3'b0, p[8]};
        w_y_neg = {3'b0, p[0]} + {2'b0, p[1], 1'b0} + {3'b0, p[2]};
        // Range is +-1020, so the 11-bit two's-complement difference is exact
        w_gx    = $signed(w_x_pos - w_x_neg);
        w_gy    = $signed(w_y_pos - w_y_neg);
    end

    // Next-state for both stages; data holds when the feeding valid is low
    always_comb begin
        sign_x_d    = sign_x_q;
        sign_y_d    = sign_y_q;
        abs_x_d     = abs_x_q;
        abs_y_d     = abs_y_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        xy_valid_d  = bus.gradient_data_in_valid;
        mag_d       = mag_q;
        dir_d       = dir_q;
        pix_d       = pix_q;
        out_valid_d = xy_valid_q;

        // tan(22.5deg) ~ 0.4 comparisons, widened so 5*1020 cannot overflow
        w_ax5 = 13'(abs_x_q) * 13'd5;
        w_ax2 = {2'b0, abs_x_q, 1'b0};
        w_ay5 = 13'(abs_y_q) * 13'd5;
        w_ay2 = {2'b0, abs_y_q, 1'b0};

        if (bus.gradient_data_in_valid) begin
            sign_x_d = w_gx[10];
            sign_y_d = w_gy[10];
            abs_x_d  = w_gx[10] ? 10'(-w_gx) : 10'(w_gx);
            abs_y_d  = w_gy[10] ? 10'(-w_gy) : 10'(w_gy);
            pix_x_d  = (abs_x_d > 10'd255) ? 8'hFF : abs_x_d[7:0];
            pix_y_d  = (abs_y_d > 10'd255) ? 8'hFF : abs_y_d[7:0];
        end

        if (xy_valid_q) begin
            mag_d = {1'b0, abs_x_q} + {1'b0, abs_y_q};
            pix_d = (mag_d > 11'd255) ? 8'hFF : mag_d[7:0];
            // A zero component never reaches the sign test: ax=0 or ay=0
            // is always resolved by one of the first two comparisons.
            if (w_ay5 <= w_ax2) begin
                dir_d = C_DIR_0;
            end else if (w_ay2 >= w_ax5) begin
                dir_d = C_DIR_90;
            end else if (sign_x_q == sign_y_q) begin
                dir_d = C_DIR_45;
            end else begin
                dir_d = C_DIR_135;
            end
        end
    end

    // Pipeline registers, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            sign_x_q    <= 1'b0;
            sign_y_q    <= 1'b0;
            abs_x_q     <= '0;
            abs_y_q     <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            xy_valid_q  <= 1'b0;
            mag_q       <= '0;
            dir_q       <= '0;
            pix_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sign_x_q    <= sign_x_d;
            sign_y_q    <= sign_y_d;
            abs_x_q     <= abs_x_d;
            abs_y_q     <= abs_y_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            xy_valid_q  <= xy_valid_d;
            mag_q       <= mag_d;
            dir_q       <= dir_d;
            pix_q       <= pix_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.pixel_out_x        = pix_x_q;
    assign bus.pixel_out_y        = pix_y_q;
    assign bus.pixel_xy_valid     = xy_valid_q;
    assign bus.gradient_magnitude = mag_q;
    assign bus.gradient_direction = dir_q;
    assign bus.pixel_out          = pix_q;
    assign bus.gradient_out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_gradient_calc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gradient_calc
//  Purpose  : Self-checking bench for gradient_calc against a transaction-
//             level reference model (outputs appear at latency 1 and 2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_gradient_calc;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    gradient_calc_if bus ();

    gradient_calc dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected values of every output
    int e_x, e_y, e_xyv, e_mag, e_dir, e_pix, e_ov;
    // Window presented on the previous clock (feeds the latency-2 outputs)
    logic        prev_v;
    logic [71:0] prev_w;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Sobel reference from the kernel definitions, plain integer arithmetic
    function automatic void ref_model(input logic [71:0] w,
                                      output int ox, output int oy,
                                      output int omag, output int odir,
                                      output int opix);
        int p [9];
        int gx, gy, ax, ay;
        for (int k = 0; k < 9; k++) p[k] = int'(w[8*k +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        ox   = (ax > 255) ? 255 : ax;
        oy   = (ay > 255) ? 255 : ay;
        omag = ax + ay;
        opix = (omag > 255) ? 255 : omag;
        if (5*ay <= 2*ax)             odir = 0;
        else if (2*ay >= 5*ax)        odir = 2;
        else if ((gx > 0) == (gy > 0)) odir = 1;
        else                          odir = 3;
    endfunction

    function automatic logic [71:0] win(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
        return {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0],
                a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    function automatic logic [71:0] rand_win();
        logic [71:0] w;
        for (int k = 0; k < 9; k++) begin
            case ($urandom_range(0, 3))
                0:       w[8*k +: 8] = 8'd0;
                1:       w[8*k +: 8] = 8'd255;
                default: w[8*k +: 8] = 8'($urandom_range(0, 255));
            endcase
        end
        return w;
    endfunction

    task automatic clear_model();
        e_x = 0; e_y = 0; e_xyv = 0;
        e_mag = 0; e_dir = 0; e_pix = 0; e_ov = 0;
        prev_v = 1'b0;
        prev_w = '0;
    endtask

    task automatic check_all();
        check("pixel_out_x",        int'(bus.pixel_out_x),        e_x);
        check("pixel_out_y",        int'(bus.pixel_out_y),        e_y);
        check("pixel_xy_valid",     int'(bus.pixel_xy_valid),     e_xyv);
        check("gradient_magnitude", int'(bus.gradient_magnitude), e_mag);
        check("gradient_direction", int'(bus.gradient_direction), e_dir);
        check("pixel_out",          int'(bus.pixel_out),          e_pix);
        check("gradient_out_valid", int'(bus.gradient_out_valid), e_ov);
    endtask

    // One clock: present a window, advance the model, check outputs after the edge
    task automatic cycle(input logic v, input logic [71:0] w);
        int d0, d1, d2, d3, d4;
        bus.gradient_data_in       = w;
        bus.gradient_data_in_valid = v;
        @(posedge clk);
        if (rstN) begin
            clear_model();
        end else begin
            if (prev_v) ref_model(prev_w, d0, d1, e_mag, e_dir, e_pix);
            e_ov = int'(prev_v);
            if (v) ref_model(w, e_x, e_y, d2, d3, d4);
            e_xyv  = int'(v);
            prev_v = v;
            prev_w = w;
        end
        #1;
        check_all();
    endtask

    initial begin
        bus.gradient_data_in       = '0;
        bus.gradient_data_in_valid = 1'b0;
        rstN = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rstN = 1'b0;

        // Directed windows
        cycle(1'b1, win(100,100,100, 100,100,100, 100,100,100)); // flat
        cycle(1'b1, win(0,0,255, 0,0,255, 0,0,255));             // vertical edge
        cycle(1'b1, win(0,0,0, 0,0,0, 255,255,255));             // horizontal edge
        cycle(1'b1, win(0,0,0, 0,0,0, 0,0,255));                 // 45 deg
        cycle(1'b1, win(0,0,0, 0,0,0, 255,0,0));                 // 135 deg
        cycle(1'b1, win(0,0,0, 0,0,10, 0,0,0));                  // small Gx
        cycle(1'b0, '0);
        cycle(1'b0, '0);

        // Streaming: 5 back-to-back, one idle, one more
        for (int i = 0; i < 5; i++) cycle(1'b1, rand_win());
        cycle(1'b0, rand_win());
        cycle(1'b1, rand_win());
        cycle(1'b0, '0);
        cycle(1'b0, '0);

        // Randomized traffic with random gaps
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), rand_win());
        end

        // Reset with two windows in flight
        cycle(1'b1, win(0,0,255, 0,0,255, 0,0,255));
        cycle(1'b1, win(0,0,0, 0,0,0, 255,255,255));
        #2;
        rstN = 1'b1;
        #1;
        clear_model();
        check_all();
        cycle(1'b1, rand_win());
        cycle(1'b1, rand_win());
        #2;
        rstN = 1'b0;
        cycle(1'b1, win(0,0,255, 0,0,255, 0,0,255));
        cycle(1'b1, win(0,0,0, 0,0,0, 0,0,255));
        cycle(1'b0, '0);
        cycle(1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
